// File: rtl/ctrl_pkg.sv
// Opcode match tables, ALUOp encodings and per-stage control payloads for ctrl_pipe.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 11;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADDR  = 2'b00,
        ALUOP_CBZ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_CBNZ  = 2'b11
    } aluop_e;

    // Each opcode is a value plus a care-mask over instr[31:21]; zero mask bits are wildcards.
    localparam logic [OPC_W-1:0] OPC_LDUR_VAL   = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_LDUR_MSK   = 11'b11111111111;
    localparam logic [OPC_W-1:0] OPC_STUR_VAL   = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_STUR_MSK   = 11'b11111111111;
    localparam logic [OPC_W-1:0] OPC_CBZ_VAL    = 11'b10110100000;
    localparam logic [OPC_W-1:0] OPC_CBZ_MSK    = 11'b11111111000;
    localparam logic [OPC_W-1:0] OPC_CBNZ_VAL   = 11'b10110101000;
    localparam logic [OPC_W-1:0] OPC_CBNZ_MSK   = 11'b11111111000;
    localparam logic [OPC_W-1:0] OPC_ADDSUB_VAL = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_ADDSUB_MSK = 11'b10111111111;
    localparam logic [OPC_W-1:0] OPC_ANDORR_VAL = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ANDORR_MSK = 11'b11011111111;
    localparam logic [OPC_W-1:0] OPC_ADDI_VAL   = 11'b10010001000;
    localparam logic [OPC_W-1:0] OPC_ADDI_MSK   = 11'b11111111110;
    localparam logic [OPC_W-1:0] OPC_B_VAL      = 11'b00010100000;
    localparam logic [OPC_W-1:0] OPC_B_MSK      = 11'b11111100000;

    typedef struct packed {
        logic   reg2loc;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        logic   uncond;
        aluop_e aluop;
    } ctrl_t;

    typedef struct packed {
        logic   valid;
        logic   alusrc;
        aluop_e aluop;
        logic   memread;
        logic   memwrite;
        logic   branch;
        logic   uncond;
        logic   regwrite;
        logic   memtoreg;
    } ex_t;

    typedef struct packed {
        logic valid;
        logic memread;
        logic memwrite;
        logic branch;
        logic uncond;
        logic regwrite;
        logic memtoreg;
    } mem_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
    } wb_t;

    function automatic logic opc_match(input logic [OPC_W-1:0] op,
                                       input logic [OPC_W-1:0] val,
                                       input logic [OPC_W-1:0] msk);
        return ((op & msk) == (val & msk));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main-control decode of instr[31:21], plus source-usage and legality flags.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] op_i,
    output ctrl_t            ctrl_o,
    output logic             rn_used_o,
    output logic             rm_used_o,
    output logic             known_o
);

    always_comb begin
        ctrl_o    = '0;
        rn_used_o = 1'b0;
        rm_used_o = 1'b0;
        known_o   = 1'b0;
        if (opc_match(op_i, OPC_LDUR_VAL, OPC_LDUR_MSK)) begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.memread  = 1'b1;
            ctrl_o.aluop    = ALUOP_ADDR;
            rn_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_STUR_VAL, OPC_STUR_MSK)) begin
            ctrl_o.reg2loc  = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memwrite = 1'b1;
            ctrl_o.aluop    = ALUOP_ADDR;
            rn_used_o       = 1'b1;
            rm_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_CBZ_VAL, OPC_CBZ_MSK)) begin
            ctrl_o.reg2loc  = 1'b1;
            ctrl_o.branch   = 1'b1;
            ctrl_o.aluop    = ALUOP_CBZ;
            rm_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_CBNZ_VAL, OPC_CBNZ_MSK)) begin
            ctrl_o.reg2loc  = 1'b1;
            ctrl_o.branch   = 1'b1;
            ctrl_o.aluop    = ALUOP_CBNZ;
            rm_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_ADDSUB_VAL, OPC_ADDSUB_MSK) ||
                     opc_match(op_i, OPC_ANDORR_VAL, OPC_ANDORR_MSK)) begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALUOP_RTYPE;
            rn_used_o       = 1'b1;
            rm_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_ADDI_VAL, OPC_ADDI_MSK)) begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.aluop    = ALUOP_RTYPE;
            rn_used_o       = 1'b1;
            known_o         = 1'b1;
        end else if (opc_match(op_i, OPC_B_VAL, OPC_B_MSK)) begin
            ctrl_o.uncond   = 1'b1;
            ctrl_o.aluop    = ALUOP_ADDR;
            known_o         = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID-to-WB control pipeline with flush, sticky illegal-opcode flag and optional load-use stall.
// Build option: define LOAD_USE_STALL_EN to enable hazard detection, stall and bubble counter.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [31:0]        id_instr,
    input  logic               ex_flush,
    output logic               id_reg2loc,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_W-1:0]   ex_rd,
    output logic               mem_valid,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_branch,
    output logic               mem_uncond,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_rd,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   bubble_cnt
);

    ctrl_t            id_ctrl;
    logic             id_rn_used;
    logic             id_rm_used;
    logic             id_known;
    logic             id_accept;
    logic [REG_W-1:0] id_rd;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;

    ex_t              ex_d,  ex_q;
    mem_t             mem_d, mem_q;
    wb_t              wb_d,  wb_q;
    logic [REG_W-1:0] ex_rd_d,  ex_rd_q;
    logic [REG_W-1:0] mem_rd_d, mem_rd_q;
    logic [REG_W-1:0] wb_rd_d,  wb_rd_q;
    logic             illegal_d, illegal_q;

    ctrl_decode u_decode (
        .op_i      (id_instr[31:21]),
        .ctrl_o    (id_ctrl),
        .rn_used_o (id_rn_used),
        .rm_used_o (id_rm_used),
        .known_o   (id_known)
    );

    assign id_rd      = REG_W'(id_instr[4:0]);
    assign id_rn      = REG_W'(id_instr[9:5]);
    assign id_rm      = id_ctrl.reg2loc ? id_rd : REG_W'(id_instr[20:16]);
    assign id_reg2loc = id_ctrl.reg2loc;
    assign id_accept  = id_valid & ~stall & ~ex_flush;

    // Shift/immediate fields never influence control.
    logic unused_instr;
    assign unused_instr = ^id_instr[15:10];

`ifdef LOAD_USE_STALL_EN
    logic hazard;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // A load in EX whose destination feeds a source actually read by the ID instruction.
    always_comb begin
        hazard = id_valid & ex_q.valid & ex_q.memread &
                 (ex_rd_q != REG_W'(ZERO_REG)) &
                 ((id_rn_used & (ex_rd_q == id_rn)) | (id_rm_used & (ex_rd_q == id_rm)));
    end

    assign stall = hazard & ~ex_flush;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;
`else
    logic unused_hazard;
    assign unused_hazard = ^{id_rn, id_rm, id_rn_used, id_rm_used, REG_W'(ZERO_REG)};
    assign stall         = 1'b0;
    assign bubble_cnt    = '0;
`endif

    // Stage advance: a bubble is an all-zero stage, so flush/stall simply skip the load.
    always_comb begin
        ex_d     = '0;
        ex_rd_d  = '0;
        mem_d    = '0;
        mem_rd_d = '0;
        wb_d     = '0;
        wb_rd_d  = '0;

        if (id_accept) begin
            ex_d.valid    = 1'b1;
            ex_d.alusrc   = id_ctrl.alusrc;
            ex_d.aluop    = id_ctrl.aluop;
            ex_d.memread  = id_ctrl.memread;
            ex_d.memwrite = id_ctrl.memwrite;
            ex_d.branch   = id_ctrl.branch;
            ex_d.uncond   = id_ctrl.uncond;
            ex_d.regwrite = id_ctrl.regwrite;
            ex_d.memtoreg = id_ctrl.memtoreg;
            ex_rd_d       = id_rd;
        end

        if (!ex_flush) begin
            mem_d.valid    = ex_q.valid;
            mem_d.memread  = ex_q.memread;
            mem_d.memwrite = ex_q.memwrite;
            mem_d.branch   = ex_q.branch;
            mem_d.uncond   = ex_q.uncond;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.memtoreg = ex_q.memtoreg;
            mem_rd_d       = ex_rd_q;
        end

        wb_d.valid    = mem_q.valid;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.memtoreg = mem_q.memtoreg;
        wb_rd_d       = mem_rd_q;

        illegal_d = illegal_q | (id_accept & ~id_known);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= '0;
            ex_rd_q   <= '0;
            mem_q     <= '0;
            mem_rd_q  <= '0;
            wb_q      <= '0;
            wb_rd_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            ex_rd_q   <= ex_rd_d;
            mem_q     <= mem_d;
            mem_rd_q  <= mem_rd_d;
            wb_q      <= wb_d;
            wb_rd_q   <= wb_rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ex_q.aluop;
    assign ex_rd        = ex_rd_q;
    assign mem_valid    = mem_q.valid;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_branch   = mem_q.branch;
    assign mem_uncond   = mem_q.uncond;
    assign wb_valid     = wb_q.valid;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_rd        = wb_rd_q;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations follow LOAD_USE_STALL_EN when it is defined.
module tb_ctrl_pipe;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic              ex_flush;
    logic              id_reg2loc, stall;
    logic              ex_valid, ex_alusrc;
    logic [1:0]        ex_aluop;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_valid, mem_memread, mem_memwrite, mem_branch, mem_uncond;
    logic              wb_valid, wb_regwrite, wb_memtoreg;
    logic [REG_W-1:0]  wb_rd;
    logic              illegal_op;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    ctrl_pipe #(.REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .ex_flush(ex_flush),
        .id_reg2loc(id_reg2loc), .stall(stall), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_branch(mem_branch), .mem_uncond(mem_uncond),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .illegal_op(illegal_op), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ldur(input logic [4:0] rn, input logic [4:0] rt);
        return {11'b11111000010, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] stur(input logic [4:0] rn, input logic [4:0] rt);
        return {11'b11111000000, 9'd0, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rn, input logic [4:0] rd);
        return {10'b1001000100, 12'd1, rn, rd};
    endfunction
    function automatic logic [31:0] cbz(input logic [18:0] imm, input logic [4:0] rt);
        return {8'b10110100, imm, rt};
    endfunction
    function automatic logic [31:0] cbnz(input logic [18:0] imm, input logic [4:0] rt);
        return {8'b10110101, imm, rt};
    endfunction

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    task automatic drain();
        id_valid = 1'b0;
        ex_flush = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset    = 1'b1;
        id_valid = 1'b0;
        id_instr = '0;
        ex_flush = 1'b0;
        tick();
        tick();
        chk("rst_ex_valid",  32'(ex_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_wb_valid",  32'(wb_valid), 32'd0);
        chk("rst_wb_rd",     32'(wb_rd), 32'd0);
        chk("rst_illegal",   32'(illegal_op), 32'd0);
        chk("rst_bubble",    32'(bubble_cnt), 32'd0);

        // Load-use: LDUR X1 then ADD X2,X1,X3
        reset    = 1'b0;
        id_valid = 1'b1;
        id_instr = ldur(5'd2, 5'd1);
        #1;
        chk("lu_stall_ldur", 32'(stall), 32'd0);
        tick();
        chk("lu_ex_valid", 32'(ex_valid), 32'd1);
        chk("lu_ex_rd",    32'(ex_rd), 32'd1);
        chk("lu_ex_alusrc", 32'(ex_alusrc), 32'd1);
        chk("lu_ex_aluop", 32'(ex_aluop), 32'd0);
        id_instr = rtype(OP_ADD, 5'd3, 5'd1, 5'd2);
        #1;
`ifdef LOAD_USE_STALL_EN
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bub_ex_valid",  32'(ex_valid), 32'd0);
        chk("lu_bub_ex_alusrc", 32'(ex_alusrc), 32'd0);
        chk("lu_bub_mem_read",  32'(mem_memread), 32'd1);
        chk("lu_bubble_cnt",    32'(bubble_cnt), 32'd1);
        chk("lu_stall_clear",   32'(stall), 32'd0);
        tick();
        chk("lu_add_ex_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_ex_rd",    32'(ex_rd), 32'd2);
        chk("lu_add_aluop",    32'(ex_aluop), 32'd2);
        chk("lu_mem_bubble",   32'(mem_valid), 32'd0);
        chk("lu_wb_rd",        32'(wb_rd), 32'd1);
        chk("lu_wb_memtoreg",  32'(wb_memtoreg), 32'd1);
`else
        chk("lu_stall_off", 32'(stall), 32'd0);
        tick();
        chk("lu_add_ex_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_ex_rd",    32'(ex_rd), 32'd2);
        chk("lu_add_aluop",    32'(ex_aluop), 32'd2);
        chk("lu_mem_read",     32'(mem_memread), 32'd1);
        chk("lu_bubble_off",   32'(bubble_cnt), 32'd0);
`endif
        drain();

        // XZR destination never creates a hazard
        id_valid = 1'b1;
        id_instr = ldur(5'd2, 5'd31);
        tick();
        id_instr = rtype(OP_ADD, 5'd3, 5'd31, 5'd2);
        #1;
        chk("xzr_stall", 32'(stall), 32'd0);
        tick();
        chk("xzr_ex_valid", 32'(ex_valid), 32'd1);
        chk("xzr_ex_rd",    32'(ex_rd), 32'd2);
        chk("xzr_mem_read", 32'(mem_memread), 32'd1);
        drain();

        // CBZ reads only Rt via Reg2Loc; Rn field is ignored. Flush overrides stall.
        id_valid = 1'b1;
        id_instr = ldur(5'd2, 5'd4);
        tick();
        id_instr = cbz(19'd4, 5'd5);
        #1;
        chk("cbz_rn_stall",   32'(stall), 32'd0);
        chk("cbz_reg2loc",    32'(id_reg2loc), 32'd1);
        id_instr = cbz(19'd0, 5'd4);
        #1;
`ifdef LOAD_USE_STALL_EN
        chk("cbz_rt_stall", 32'(stall), 32'd1);
`else
        chk("cbz_rt_stall", 32'(stall), 32'd0);
`endif
        ex_flush = 1'b1;
        #1;
        chk("flush_over_stall", 32'(stall), 32'd0);
        tick();
        chk("cbz_fl_ex_valid",  32'(ex_valid), 32'd0);
        chk("cbz_fl_mem_valid", 32'(mem_valid), 32'd0);
        chk("cbz_fl_mem_read",  32'(mem_memread), 32'd0);
        drain();

        // Flush with ADD in ID: EX and MEM bubble, WB takes prior MEM (ADDI X7)
        id_valid = 1'b1;
        id_instr = addi(5'd1, 5'd7);
        tick();
        id_instr = rtype(OP_ORR, 5'd3, 5'd1, 5'd8);
        tick();
        chk("fl_pre_mem_valid", 32'(mem_valid), 32'd1);
        id_instr = rtype(OP_ADD, 5'd3, 5'd1, 5'd9);
        ex_flush = 1'b1;
        tick();
        chk("fl_ex_valid",    32'(ex_valid), 32'd0);
        chk("fl_ex_rd",       32'(ex_rd), 32'd0);
        chk("fl_mem_valid",   32'(mem_valid), 32'd0);
        chk("fl_wb_valid",    32'(wb_valid), 32'd1);
        chk("fl_wb_regwrite", 32'(wb_regwrite), 32'd1);
        chk("fl_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
        chk("fl_wb_rd",       32'(wb_rd), 32'd7);
        drain();

        // CBNZ, B, ADDI streamed
        id_valid = 1'b1;
        id_instr = cbnz(19'd4, 5'd3);
        #1;
        chk("st_cbnz_reg2loc", 32'(id_reg2loc), 32'd1);
        tick();
        chk("st_cbnz_aluop", 32'(ex_aluop), 32'd3);
        id_instr = {6'b000101, 26'd16};
        #1;
        chk("st_b_reg2loc", 32'(id_reg2loc), 32'd0);
        tick();
        chk("st_b_aluop",      32'(ex_aluop), 32'd0);
        chk("st_cbnz_branch",  32'(mem_branch), 32'd1);
        chk("st_cbnz_uncond",  32'(mem_uncond), 32'd0);
        id_instr = addi(5'd1, 5'd6);
        tick();
        chk("st_addi_aluop",  32'(ex_aluop), 32'd2);
        chk("st_b_uncond",    32'(mem_uncond), 32'd1);
        chk("st_b_branch",    32'(mem_branch), 32'd0);
        id_valid = 1'b0;
        tick();
        chk("st_addi_uncond", 32'(mem_uncond), 32'd0);
        chk("st_b_wb_valid",  32'(wb_valid), 32'd1);
        chk("st_b_wb_regwr",  32'(wb_regwrite), 32'd0);
        chk("st_illegal",     32'(illegal_op), 32'd0);
        drain();

        // Reg2Loc decodes even without id_valid; invalid ID yields an EX bubble
        id_valid = 1'b0;
        id_instr = stur(5'd2, 5'd5);
        #1;
        chk("inv_reg2loc", 32'(id_reg2loc), 32'd1);
        tick();
        chk("inv_ex_valid",  32'(ex_valid), 32'd0);
        chk("inv_ex_alusrc", 32'(ex_alusrc), 32'd0);

        // Unknown opcode: ignored when invalid or flushed, sticky once accepted
        id_instr = 32'h0000_0000;
        tick();
        chk("ill_invalid", 32'(illegal_op), 32'd0);
        id_valid = 1'b1;
        ex_flush = 1'b1;
        tick();
        chk("ill_flushed", 32'(illegal_op), 32'd0);
        ex_flush = 1'b0;
        tick();
        chk("ill_set",       32'(illegal_op), 32'd1);
        chk("ill_ex_valid",  32'(ex_valid), 32'd1);
        chk("ill_ex_aluop",  32'(ex_aluop), 32'd0);
        chk("ill_ex_alusrc", 32'(ex_alusrc), 32'd0);
        id_valid = 1'b0;
        tick();
        chk("ill_mem_valid", 32'(mem_valid), 32'd1);
        chk("ill_mem_read",  32'(mem_memread), 32'd0);
        chk("ill_mem_write", 32'(mem_memwrite), 32'd0);
        tick();
        chk("ill_wb_valid", 32'(wb_valid), 32'd1);
        chk("ill_wb_regwr", 32'(wb_regwrite), 32'd0);
        drain();

`ifdef LOAD_USE_STALL_EN
        // Eight more stalls on a 3-bit counter already at 1: must stop at 7
        for (int i = 0; i < 8; i++) begin
            id_valid = 1'b1;
            id_instr = ldur(5'd2, 5'd1);
            tick();
            id_instr = rtype(OP_ADD, 5'd1, 5'd3, 5'd2);
            tick();
            chk($sformatf("sat_cnt_%0d", i), 32'(bubble_cnt), (i + 2 > 7) ? 32'd7 : 32'(i + 2));
        end
        drain();
`else
        chk("cnt_tied_zero", 32'(bubble_cnt), 32'd0);
`endif
        chk("ill_persist", 32'(illegal_op), 32'd1);

        // Reset mid-flush/stall wins; first edge after release accepts ID
        id_valid = 1'b1;
        id_instr = ldur(5'd2, 5'd1);
        tick();
        id_instr = rtype(OP_ADD, 5'd3, 5'd1, 5'd2);
        ex_flush = 1'b1;
        reset    = 1'b1;
        tick();
        chk("mrst_ex_valid",  32'(ex_valid), 32'd0);
        chk("mrst_ex_rd",     32'(ex_rd), 32'd0);
        chk("mrst_mem_valid", 32'(mem_valid), 32'd0);
        chk("mrst_wb_valid",  32'(wb_valid), 32'd0);
        chk("mrst_illegal",   32'(illegal_op), 32'd0);
        chk("mrst_bubble",    32'(bubble_cnt), 32'd0);
        reset    = 1'b0;
        ex_flush = 1'b0;
        #1;
        chk("post_rst_stall", 32'(stall), 32'd0);
        tick();
        chk("post_rst_ex_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_ex_rd",    32'(ex_rd), 32'd2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
